update_receiver: RTL and testbench
==================================

UPDATE_RECEIVER -- requirements
Module: update_receiver

Interface
REQ-001 SHALL have parameter V_ID_WIDTH, default `V_ID_WIDTH (32), vertex id width.
REQ-002 SHALL have parameter V_VALUE_WIDTH, default `V_VALUE_WIDTH (32), vertex value width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entries in the update buffer (power of two, at least 4).
REQ-004 SHALL have parameter FULL_THRESH, default 12, occupancy at which backpressure is raised (FULL_THRESH <= FIFO_DEPTH-3).
REQ-005 clk  input  1  the single clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 push_flag  input  1  update is push-mode.
REQ-008 update_v_id  input  V_ID_WIDTH  update vertex id.
REQ-009 update_v_value  input  V_VALUE_WIDTH  update value.
REQ-010 pull_first_flag  input  1  update originated from the pull path.
REQ-011 update_v_valid  input  1  update beat valid; no ready, qualified only by next_stage_full.
REQ-012 iteration_end  input  1  scheduler iteration-end.
REQ-013 iteration_end_valid  input  1  qualifies iteration_end.
REQ-014 out_ready  input  1  downstream accepts out_* beat.
REQ-015 next_stage_full  output  1  backpressure to scheduler.
REQ-016 out_push_flag, out_pull_first_flag  output  1 each  forwarded flags.
REQ-017 out_v_id / out_v_value  output  V_ID_WIDTH / V_VALUE_WIDTH  forwarded update.
REQ-018 out_valid  output  1  out_* beat valid.
REQ-019 iter_done  output  1  one-cycle pulse: iteration drained.
REQ-020 overflow  output  1  sticky: a beat was dropped.
REQ-021 iter_update_count  output  32  updates accepted in last completed iteration (only with UPDATE_RECV_COUNT_EN).

Function
REQ-022 Each sampled update_v_valid SHALL write {push_flag, pull_first_flag, update_v_id, update_v_value} into the FIFO, preserving order.
REQ-023 next_stage_full SHALL be registered, high in the cycle after occupancy >= FULL_THRESH is reached, low the cycle after occupancy < FULL_THRESH.
REQ-024 A write when occupancy == FIFO_DEPTH with no same-cycle FIFO read SHALL be dropped and set overflow; a same-cycle read SHALL make the write succeed.
REQ-025 Output stage SHALL be a register: it loads the FIFO head when empty or when out_valid && out_ready; with FIFO and stage empty, a beat sampled at edge N SHALL show out_valid after edge N+1.
REQ-026 out_* SHALL hold stable while out_valid && !out_ready; out_valid deasserts only after transfer with no next entry.
REQ-027 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-028 FSM states RUN, DRAIN, DONE: RUN->DRAIN on iteration_end && iteration_end_valid; DRAIN->DONE when FIFO empty and out_valid low; DONE->RUN unconditionally next cycle.
REQ-029 iter_done SHALL be high exactly during the DONE cycle.
REQ-030 iteration_end pulses during DRAIN or DONE SHALL be ignored; updates arriving in DRAIN SHALL be accepted and delay DONE until drained.
REQ-031 iteration_end in same cycle as a write SHALL count and drain that write within the ending iteration.

Reset
REQ-032 rst_n low SHALL asynchronously clear FIFO pointers/occupancy, FSM to RUN, and all outputs to 0 (next_stage_full, out_*, out_valid, iter_done, overflow, iter_update_count).
REQ-033 Reset mid-operation SHALL discard buffered beats; no out_valid until a new write after rst_n rises.

Configuration
REQ-034 Macro UPDATE_RECV_COUNT_EN defined: a 32-bit counter SHALL count accepted (non-dropped) writes, copy into iter_update_count at entry to DONE, then restart from 0 (a write in the DONE cycle counts as 1 for the next iteration); counter wraps at 2^32.
REQ-035 Macro UPDATE_RECV_COUNT_EN undefined: counter and iter_update_count port SHALL not exist; all other behaviour unchanged.

Verification
REQ-036 Single beat id=5, value=9, push=1, FIFO empty, out_ready=1 -> out_valid after edge N+1 with id=5, value=9, push=1, one cycle.
REQ-037 out_ready=0, 12 back-to-back beats -> next_stage_full high after the 12th write; no overflow; releasing out_ready drains all 12 in order, next_stage_full drops at occupancy 11.
REQ-038 out_ready=0, 17 beats with scheduler ignoring backpressure -> 16 stored, overflow=1 and sticky, 17th absent from output.
REQ-039 3 beats then iteration_end&&valid, out_ready=1 -> iter_done pulses one cycle after last out transfer; iter_update_count=3 with UPDATE_RECV_COUNT_EN.
REQ-040 iteration_end during DRAIN plus 2 extra beats -> single iter_done after those 2 drain; count=5 for that iteration.
REQ-041 rst_n pulsed low with 8 beats buffered -> all outputs 0 immediately; no stale beat emerges after release.

Source files
------------

// File: rtl/update_receiver.sv
// Update receiver: buffers scheduler updates in a FIFO behind a registered output stage
// and tracks iteration drain. Optional per-iteration update counter: UPDATE_RECV_COUNT_EN.
`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef V_VALUE_WIDTH
`define V_VALUE_WIDTH 32
`endif

module update_receiver #(
   parameter int V_ID_WIDTH    = `V_ID_WIDTH,
   parameter int V_VALUE_WIDTH = `V_VALUE_WIDTH,
   parameter int FIFO_DEPTH    = 16,
   parameter int FULL_THRESH   = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_flag,
   input  logic [V_ID_WIDTH-1:0]    update_v_id,
   input  logic [V_VALUE_WIDTH-1:0] update_v_value,
   input  logic                     pull_first_flag,
   input  logic                     update_v_valid,
   input  logic                     iteration_end,
   input  logic                     iteration_end_valid,
   input  logic                     out_ready,
   output logic                     next_stage_full,
   output logic                     out_push_flag,
   output logic                     out_pull_first_flag,
   output logic [V_ID_WIDTH-1:0]    out_v_id,
   output logic [V_VALUE_WIDTH-1:0] out_v_value,
   output logic                     out_valid,
   output logic                     iter_done,
`ifdef UPDATE_RECV_COUNT_EN
   output logic [31:0]              iter_update_count,
`endif
   output logic                     overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic                     push;
      logic                     pull_first;
      logic [V_ID_WIDTH-1:0]    id;
      logic [V_VALUE_WIDTH-1:0] value;
   } beat_t;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   beat_t           r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]   r_fifo_cnt;
   beat_t           r_out;
   logic            r_out_valid;
   logic            r_nsf;
   logic            r_overflow;
   logic            r_iter_done;
   state_t          r_state;

   beat_t           w_in;
   logic            w_xfer, w_load, w_fifo_empty, w_rd, w_wr, w_drain_done;
   logic [CW-1:0]   w_occ;

   // Occupancy counts every beat held here, including the one in the output stage.
   assign w_in         = '{push: push_flag, pull_first: pull_first_flag,
                           id: update_v_id, value: update_v_value};
   assign w_xfer       = r_out_valid && out_ready;
   assign w_load       = !r_out_valid || out_ready;
   assign w_fifo_empty = (r_fifo_cnt == '0);
   assign w_rd         = w_load && !w_fifo_empty;
   assign w_occ        = r_fifo_cnt + CW'(r_out_valid);
   assign w_wr         = update_v_valid && ((w_occ != CW'(FIFO_DEPTH)) || w_xfer);
   assign w_drain_done = w_fifo_empty && !r_out_valid && !update_v_valid;

   // NOTE: storage array has no reset; validity lives entirely in the pointers/count.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_in;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_fifo_cnt  <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_nsf       <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_fifo_cnt <= r_fifo_cnt + CW'(w_wr) - CW'(w_rd);
         if (w_load) r_out_valid <= !w_fifo_empty;
         if (w_rd)   r_out       <= r_mem[r_rd_ptr];
         r_nsf <= (w_occ >= CW'(FULL_THRESH));
         if (update_v_valid && !w_wr) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RUN;
         r_iter_done <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_iter_done <= 1'b0;
               if (iteration_end && iteration_end_valid) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_drain_done) begin
                  r_state     <= S_DONE;
                  r_iter_done <= 1'b1;
               end
            end
            S_DONE: begin
               r_state     <= S_RUN;
               r_iter_done <= 1'b0;
            end
            default: begin
               r_state     <= S_RUN;
               r_iter_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef UPDATE_RECV_COUNT_EN
   logic [31:0] r_upd_cnt;
   logic [31:0] r_iter_cnt_out;

   // A write landing in the DONE cycle is the first one of the next iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_upd_cnt      <= '0;
         r_iter_cnt_out <= '0;
      end else begin
         if (r_state == S_DONE) r_upd_cnt <= 32'(w_wr);
         else                   r_upd_cnt <= r_upd_cnt + 32'(w_wr);
         if (r_state == S_DRAIN && w_drain_done) r_iter_cnt_out <= r_upd_cnt;
      end
   end

   assign iter_update_count = r_iter_cnt_out;
`endif

   assign next_stage_full     = r_nsf;
   assign out_push_flag       = r_out.push;
   assign out_pull_first_flag = r_out.pull_first;
   assign out_v_id            = r_out.id;
   assign out_v_value         = r_out.value;
   assign out_valid           = r_out_valid;
   assign iter_done           = r_iter_done;
   assign overflow            = r_overflow;

endmodule

// File: tb/tb_update_receiver.sv
// Scoreboard bench for update_receiver: occupancy/iteration reference model plus directed scenarios.
module tb_update_receiver;

   localparam int IDW    = 32;
   localparam int VW     = 32;
   localparam int DEPTH  = 16;
   localparam int THRESH = 12;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           push_flag = 1'b0, pull_first_flag = 1'b0, update_v_valid = 1'b0;
   logic [IDW-1:0] update_v_id = '0;
   logic [VW-1:0]  update_v_value = '0;
   logic           iteration_end = 1'b0, iteration_end_valid = 1'b0, out_ready = 1'b0;
   logic           next_stage_full, out_push_flag, out_pull_first_flag, out_valid;
   logic           iter_done, overflow;
   logic [IDW-1:0] out_v_id;
   logic [VW-1:0]  out_v_value;
   logic [31:0]    iter_update_count;

   update_receiver #(.V_ID_WIDTH(IDW), .V_VALUE_WIDTH(VW), .FIFO_DEPTH(DEPTH),
                     .FULL_THRESH(THRESH)) dut (
      .clk(clk), .rst_n(rst_n), .push_flag(push_flag), .update_v_id(update_v_id),
      .update_v_value(update_v_value), .pull_first_flag(pull_first_flag),
      .update_v_valid(update_v_valid), .iteration_end(iteration_end),
      .iteration_end_valid(iteration_end_valid), .out_ready(out_ready),
      .next_stage_full(next_stage_full), .out_push_flag(out_push_flag),
      .out_pull_first_flag(out_pull_first_flag), .out_v_id(out_v_id),
      .out_v_value(out_v_value), .out_valid(out_valid), .iter_done(iter_done),
`ifdef UPDATE_RECV_COUNT_EN
      .iter_update_count(iter_update_count),
`endif
      .overflow(overflow));

`ifndef UPDATE_RECV_COUNT_EN
   assign iter_update_count = '0;
`endif

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic           push;
      logic           pull;
      logic [IDW-1:0] id;
      logic [VW-1:0]  val;
   } beat_t;

   // Reference model: beats held = accepted minus delivered; iteration tracked as
   // "draining" until nothing is held and no beat is arriving.
   beat_t       exp_q[$];
   int          occ = 0;
   bit          draining = 0, exp_done = 0, exp_ovf = 0, exp_nsf = 0;
   logic [31:0] iter_cnt = '0, exp_iuc = '0;

   always @(posedge clk or negedge rst_n) begin
      bit    xfer, nd, acc;
      int    occ0;
      beat_t b;
      if (!rst_n) begin
         exp_q.delete();
         occ = 0; draining = 0; exp_done = 0; exp_ovf = 0; exp_nsf = 0;
         iter_cnt = '0; exp_iuc = '0;
      end else begin
         xfer = out_valid && out_ready;
         occ0 = occ;
         if (xfer) begin
            if (exp_q.size() == 0) check("spurious_beat", 1, 0);
            else begin
               b = exp_q.pop_front();
               check("out_v_id", out_v_id, b.id);
               check("out_v_value", out_v_value, b.val);
               check("out_flags", {out_push_flag, out_pull_first_flag}, {b.push, b.pull});
            end
         end
         exp_nsf = (occ0 >= THRESH);
         acc = 0;
         if (update_v_valid) begin
            if (occ0 == DEPTH && !xfer) exp_ovf = 1;
            else begin
               acc = 1;
               b = '{push: push_flag, pull: pull_first_flag, id: update_v_id, val: update_v_value};
               exp_q.push_back(b);
               occ++;
            end
         end
         if (xfer) occ--;
         nd = draining && (occ0 == 0) && !update_v_valid;
         if (nd) begin
            draining = 0;
            exp_iuc  = iter_cnt;
         end else if (!draining && !exp_done && iteration_end && iteration_end_valid)
            draining = 1;
         if (exp_done) iter_cnt = 32'(acc);
         else          iter_cnt = iter_cnt + 32'(acc);
         exp_done = nd;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("next_stage_full", next_stage_full, exp_nsf);
         check("iter_done", iter_done, exp_done);
         check("overflow", overflow, exp_ovf);
`ifdef UPDATE_RECV_COUNT_EN
         check("iter_update_count", iter_update_count, exp_iuc);
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input bit p, input bit pf, input logic [31:0] id,
                       input logic [31:0] val, input bit ie);
      push_flag = p; pull_first_flag = pf; update_v_id = id; update_v_value = val;
      update_v_valid = 1'b1; iteration_end = ie; iteration_end_valid = ie;
      cyc();
      update_v_valid = 1'b0; iteration_end = 1'b0; iteration_end_valid = 1'b0;
   endtask

   task automatic pulse_end();
      iteration_end = 1'b1; iteration_end_valid = 1'b1;
      cyc();
      iteration_end = 1'b0; iteration_end_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((occ != 0 || draining || exp_done) && n < budget) begin
         cyc();
         n++;
      end
      if (n >= budget) check("drain_timeout", 1, 0);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      bit seen = 0;
      while (!seen && n < budget) begin
         cyc();
         seen = iter_done;
         n++;
      end
      check("iter_done_seen", seen, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_nsf", next_stage_full, 0);
      check("rst_iter_done", iter_done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_iuc", iter_update_count, 0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // Single beat latency: sampled at edge N, visible after N+1, for one cycle
      out_ready = 1'b1;
      send(1'b1, 1'b0, 32'd5, 32'd9, 1'b0);
      check("lat_n_valid", out_valid, 0);
      cyc();
      check("lat_n1_valid", out_valid, 1);
      check("lat_n1_id", out_v_id, 32'd5);
      check("lat_n1_value", out_v_value, 32'd9);
      check("lat_n1_push", out_push_flag, 1);
      cyc();
      check("lat_n2_valid", out_valid, 0);
      wait_idle(20);

      // Backpressure threshold with a stalled consumer
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) send(1'b0, i[0], 32'(100 + i), 32'(i * 7), 1'b0);
      check("nsf_at_12_write", next_stage_full, 0);
      cyc();
      check("nsf_after_12", next_stage_full, 1);
      check("no_ovf_12", overflow, 0);
      out_ready = 1'b1;
      wait_idle(50);
      check("nsf_released", next_stage_full, 0);

      // Randomized traffic honouring backpressure
      for (int c = 0; c < 400; c++) begin
         update_v_valid      = !next_stage_full && ($urandom_range(0, 3) != 0);
         push_flag           = 1'($urandom);
         pull_first_flag     = 1'($urandom);
         update_v_id         = $urandom;
         update_v_value      = $urandom;
         out_ready           = ($urandom_range(0, 3) != 0);
         iteration_end       = ($urandom_range(0, 30) == 0);
         iteration_end_valid = 1'($urandom);
         cyc();
      end
      update_v_valid = 1'b0; iteration_end = 1'b0; iteration_end_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle(100);
      pulse_end();
      wait_idle(100);

      // Three beats then iteration end
      for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 32'(200 + i), 32'(300 + i), 1'b0);
      pulse_end();
      wait_done(50);
`ifdef UPDATE_RECV_COUNT_EN
      check("iuc_three", iter_update_count, 32'd3);
`endif
      wait_idle(50);

      // Iteration end coincident with a write, then more beats and a second end during drain
      out_ready = 1'b0;
      send(1'b0, 1'b0, 32'd400, 32'd1, 1'b0);
      send(1'b0, 1'b1, 32'd401, 32'd2, 1'b0);
      send(1'b1, 1'b0, 32'd402, 32'd3, 1'b1);
      send(1'b1, 1'b1, 32'd403, 32'd4, 1'b1);
      send(1'b0, 1'b0, 32'd404, 32'd5, 1'b0);
      cyc();
      check("drain_no_early_done", iter_done, 0);
      out_ready = 1'b1;
      wait_done(50);
`ifdef UPDATE_RECV_COUNT_EN
      check("iuc_five", iter_update_count, 32'd5);
`endif
      wait_idle(50);

      // Overflow: 17 beats into 16 slots with a stalled consumer
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) send(1'b0, 1'b0, 32'(500 + i), 32'(600 + i), 1'b0);
      cyc();
      check("ovf_set", overflow, 1);
      out_ready = 1'b1;
      wait_idle(60);
      check("ovf_sticky", overflow, 1);

      // Reset with buffered beats
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 32'(700 + i), 32'(800 + i), 1'b0);
      cyc();
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", out_valid, 0);
      check("mrst_out_id", out_v_id, 0);
      check("mrst_out_value", out_v_value, 0);
      check("mrst_nsf", next_stage_full, 0);
      check("mrst_overflow", overflow, 0);
      check("mrst_iuc", iter_update_count, 0);
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("post_rst_idle", out_valid, 0);
      end
      send(1'b0, 1'b1, 32'd900, 32'd901, 1'b0);
      wait_idle(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
